// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex driver for common-anode 7-segment digits on a shared segment bus.
// A load strobe captures the value. Digits are scanned at SCAN_DIV clocks per slot, with blanking and leading-zero suppression.
module hex_display_scanner #(
  parameter int DIGITS      = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int LZ_SUPPRESS = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [4*DIGITS-1:0] value,
  input  logic                load,
  input  logic [DIGITS-1:0]   blank_mask,
  output logic [6:0]          HEX,
  output logic [DIGITS-1:0]   AN,
  output logic                digit_tick
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] CNT_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [6:0]    SEG_DARK = 7'b1111111;

  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    case (nib)
      4'h0: seg_encode = 7'b0000001;
      4'h1: seg_encode = 7'b1001111;
      4'h2: seg_encode = 7'b0010010;
      4'h3: seg_encode = 7'b0000110;
      4'h4: seg_encode = 7'b1001100;
      4'h5: seg_encode = 7'b0100100;
      4'h6: seg_encode = 7'b0100000;
      4'h7: seg_encode = 7'b0001111;
      4'h8: seg_encode = 7'b0000000;
      4'h9: seg_encode = 7'b0000100;
      4'hA: seg_encode = 7'b0001000;
      4'hB: seg_encode = 7'b1100000;
      4'hC: seg_encode = 7'b0110001;
      4'hD: seg_encode = 7'b1000010;
      4'hE: seg_encode = 7'b0110000;
      default: seg_encode = 7'b0111000;
    endcase
  endfunction

  logic [4*DIGITS-1:0] shadow;
  logic [PW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic                at_last;
  logic                upper_zero;
  logic [3:0]          sel_nib;
  logic                sel_blank;
  logic                sel_zero;
  logic [6:0]          hex_next;
  logic [DIGITS-1:0]   an_next;

  assign at_last    = (cnt == CNT_LAST);
  assign digit_tick = at_last & ~reset;

  // Walk from the top digit down so upper_zero means "this nibble and all above are zero".
  // The idx compare also keeps selection inside 4*DIGITS when DIGITS is not a power of two.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    upper_zero = 1'b1;
    sel_nib    = 4'h0;
    sel_blank  = 1'b0;
    sel_zero   = 1'b0;
    an_next    = '1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (shadow[4*i +: 4] == 4'h0);
      if (idx == IW'(i)) begin
        sel_nib    = shadow[4*i +: 4];
        sel_blank  = blank_mask[i];
        sel_zero   = upper_zero && (i != 0);
        an_next[i] = 1'b0;
      end
    end
    hex_next = (sel_blank || ((LZ_SUPPRESS != 0) && sel_zero)) ? SEG_DARK : seg_encode(sel_nib);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow <= '0;
      cnt    <= '0;
      idx    <= '0;
      HEX    <= SEG_DARK;
      AN     <= '1;
    end else begin
      // NOTE: non-blocking assignments so HEX/AN see the pre-edge idx and shadow.
      if (load) shadow <= value;
      cnt <= at_last ? '0 : cnt + PW'(1);
      if (at_last) idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      HEX <= hex_next;
      AN  <= an_next;
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner (DIGITS=4, SCAN_DIV=4, LZ_SUPPRESS=1).
// The reference tracks edges since reset and derives the scan slot arithmetically.
module tb_hex_display_scanner;

  localparam int D  = 4;
  localparam int SD = 4;
  localparam logic [6:0] SEG_TAB [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic        load;
  logic [3:0]  blank_mask;
  logic [6:0]  HEX;
  logic [3:0]  AN;
  logic        digit_tick;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          k;
  logic [15:0] m_shadow;
  logic [6:0]  exp_hex;
  logic [3:0]  exp_an;
  logic        exp_tick;

  hex_display_scanner #(.DIGITS(D), .SCAN_DIV(SD), .LZ_SUPPRESS(1)) dut (
    .clock(clock), .reset(reset), .value(value), .load(load),
    .blank_mask(blank_mask), .HEX(HEX), .AN(AN), .digit_tick(digit_tick));

  always #5 clock = ~clock;

  function automatic logic [6:0] ref_hex(input logic [15:0] sh, input int slot, input logic [3:0] mask);
    logic [15:0] rest;
    rest = sh >> (4 * slot);
    if (mask[slot]) return 7'b1111111;
    if (slot > 0 && rest == 16'h0) return 7'b1111111;
    return SEG_TAB[rest[3:0]];
  endfunction

  // One clock edge: drive inputs, advance the model, then settle 1 time unit past the edge.
  task automatic cycle(input logic ld, input logic [15:0] v, input logic [3:0] m);
    int slot;
    load = ld; value = v; blank_mask = m;
    @(posedge clock);
    slot    = (k / SD) % D;
    exp_hex = ref_hex(m_shadow, slot, m);
    exp_an  = 4'hF;
    exp_an[slot] = 1'b0;
    if (ld) m_shadow = v;
    k++;
    exp_tick = ((k % SD) == SD - 1);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; load = 1'b1; value = 16'h0000; blank_mask = 4'h0;
    #2;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++; if (HEX !== 7'b1111111) begin n_bad++; $display("FAIL reset_hex got %b want 1111111", HEX); end
    n_cmp++; if (AN !== 4'b1111) begin n_bad++; $display("FAIL reset_an got %b want 1111", AN); end
    n_cmp++; if (digit_tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick got %b want 0", digit_tick); end
    reset = 1'b0; k = 0; m_shadow = 16'h0;
  endtask

  task automatic test_walk;
    logic [3:0] walk [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    for (int i = 0; i < 4 * SD; i++) begin
      cycle(1'b1, 16'h0000, 4'h0);
      n_cmp++; if (AN !== walk[i / SD]) begin n_bad++; $display("FAIL walk_an cyc=%0d got %b want %b", i, AN, walk[i / SD]); end
      n_cmp++; if (HEX !== exp_hex) begin n_bad++; $display("FAIL walk_hex cyc=%0d got %b want %b", i, HEX, exp_hex); end
    end
  endtask

  task automatic test_pattern;
    cycle(1'b1, 16'h1A2F, 4'h0);
    for (int i = 0; i < 6 * SD; i++) begin
      cycle(1'b0, 16'($urandom), 4'h0);
      n_cmp++; if (HEX !== exp_hex) begin n_bad++; $display("FAIL pattern_hex k=%0d got %b want %b", k, HEX, exp_hex); end
      n_cmp++; if (AN !== exp_an) begin n_bad++; $display("FAIL pattern_an k=%0d got %b want %b", k, AN, exp_an); end
      n_cmp++; if (digit_tick !== exp_tick) begin n_bad++; $display("FAIL pattern_tick k=%0d got %b want %b", k, digit_tick, exp_tick); end
    end
  endtask

  task automatic test_lz;
    logic [15:0] vals [2] = '{16'h0030, 16'h0000};
    for (int v = 0; v < 2; v++) begin
      cycle(1'b1, vals[v], 4'h0);
      for (int i = 0; i < 4 * SD; i++) begin
        cycle(1'b0, vals[v], 4'h0);
        n_cmp++; if (HEX !== exp_hex) begin n_bad++; $display("FAIL lz_hex v=%h k=%0d got %b want %b", vals[v], k, HEX, exp_hex); end
        n_cmp++; if (AN !== exp_an) begin n_bad++; $display("FAIL lz_an v=%h k=%0d got %b want %b", vals[v], k, AN, exp_an); end
      end
    end
  endtask

  task automatic test_blank;
    cycle(1'b1, 16'h8888, 4'b0101);
    for (int i = 0; i < 4 * SD; i++) begin
      cycle(1'b0, 16'h8888, 4'b0101);
      n_cmp++; if (HEX !== exp_hex) begin n_bad++; $display("FAIL blank_hex k=%0d got %b want %b", k, HEX, exp_hex); end
      n_cmp++; if (AN !== exp_an) begin n_bad++; $display("FAIL blank_an k=%0d got %b want %b", k, AN, exp_an); end
    end
  endtask

  task automatic test_load_on_tick;
    int guard;
    for (int i = 0; i < 3 * SD; i++) begin
      cycle(1'b0, 16'($urandom), 4'h0);
      n_cmp++; if (HEX !== exp_hex) begin n_bad++; $display("FAIL noload_hex k=%0d got %b want %b", k, HEX, exp_hex); end
    end
    guard = 0;
    while (!digit_tick && guard < 2 * SD) begin
      cycle(1'b0, 16'h0000, 4'h0);
      guard++;
    end
    n_cmp++; if (digit_tick !== 1'b1) begin n_bad++; $display("FAIL tick_wait got %b want 1", digit_tick); end
    cycle(1'b1, 16'($urandom) | 16'h1111, 4'h0);
    for (int i = 0; i < 2 * SD; i++) begin
      cycle(1'b0, 16'h0000, 4'h0);
      n_cmp++; if (HEX !== exp_hex) begin n_bad++; $display("FAIL tickload_hex k=%0d got %b want %b", k, HEX, exp_hex); end
      n_cmp++; if (digit_tick !== exp_tick) begin n_bad++; $display("FAIL tickload_tick k=%0d got %b want %b", k, digit_tick, exp_tick); end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 200; i++) begin
      cycle(($urandom_range(0, 3) == 0), 16'($urandom), 4'($urandom));
      n_cmp++; if (HEX !== exp_hex) begin n_bad++; $display("FAIL rand_hex k=%0d got %b want %b", k, HEX, exp_hex); end
      n_cmp++; if (AN !== exp_an) begin n_bad++; $display("FAIL rand_an k=%0d got %b want %b", k, AN, exp_an); end
      n_cmp++; if (digit_tick !== exp_tick) begin n_bad++; $display("FAIL rand_tick k=%0d got %b want %b", k, digit_tick, exp_tick); end
    end
  endtask

  task automatic test_reset_mid;
    int guard = 0;
    while (!(((k / SD) % D) == 2 && (k % SD) == 1) && guard < 2 * SD * D) begin
      cycle(1'b0, 16'h0000, 4'h0);
      guard++;
    end
    n_cmp++; if (((k / SD) % D) != 2) begin n_bad++; $display("FAIL midreset_reach got slot %0d want 2", (k / SD) % D); end
    n_cmp++; if (AN !== 4'b1011) begin n_bad++; $display("FAIL midreset_pre_an got %b want 1011", AN); end
    reset = 1'b1;
    #1;
    n_cmp++; if (HEX !== 7'b1111111) begin n_bad++; $display("FAIL midreset_hex got %b want 1111111", HEX); end
    n_cmp++; if (AN !== 4'b1111) begin n_bad++; $display("FAIL midreset_an got %b want 1111", AN); end
    n_cmp++; if (digit_tick !== 1'b0) begin n_bad++; $display("FAIL midreset_tick got %b want 0", digit_tick); end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0; k = 0; m_shadow = 16'h0;
    for (int i = 0; i < 2 * SD; i++) begin
      cycle(1'b0, 16'hFFFF, 4'h0);
      n_cmp++; if (AN !== exp_an) begin n_bad++; $display("FAIL postreset_an cyc=%0d got %b want %b", i, AN, exp_an); end
      n_cmp++; if (HEX !== exp_hex) begin n_bad++; $display("FAIL postreset_hex cyc=%0d got %b want %b", i, HEX, exp_hex); end
    end
  endtask

  initial begin
    test_reset;
    test_walk;
    test_pattern;
    test_lz;
    test_blank;
    test_load_on_tick;
    test_random;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
